// File: rtl/neuron_seq_pkg.sv
// Shared types for the neuron sequencer: operand format and FSM state encoding.
package neuron_seq_pkg;

    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  expo;
    } float_24_8;

    localparam logic [1:0] SEQ_IDLE  = 2'd0;
    localparam logic [1:0] SEQ_RUN   = 2'd1;
    localparam logic [1:0] SEQ_DRAIN = 2'd2;
    localparam logic [1:0] SEQ_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = SEQ_IDLE,
        ST_RUN   = SEQ_RUN,
        ST_DRAIN = SEQ_DRAIN,
        ST_DONE  = SEQ_DONE
    } seq_state_t;

endpackage

// File: rtl/neuron_seq_if.sv
// Control, memory-address and neuron-framing signals between the layer controller and the sequencer.
interface neuron_seq_if #(parameter int ADDR_W = 10);

    logic              start;
    logic [ADDR_W-1:0] num_taps;
    logic [ADDR_W-1:0] num_outs;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] data_addr;
    logic [ADDR_W-1:0] tap_addr;
    logic [ADDR_W-1:0] bias_addr;
    logic              in_valid;
    logic              first;
    logic              last;
    logic              out_valid;
    logic [ADDR_W-1:0] out_index;

    modport master (
        output start, num_taps, num_outs,
        input  busy, done, rd_en, data_addr, tap_addr, bias_addr,
        input  in_valid, first, last, out_valid, out_index
    );

    modport slave (
        input  start, num_taps, num_outs,
        output busy, done, rd_en, data_addr, tap_addr, bias_addr,
        output in_valid, first, last, out_valid, out_index
    );

endinterface

// File: rtl/neuron_seq_delay_line.sv
// Fixed-depth shift register with synchronous clear.
// Latency: DEPTH cycles; no backpressure (shifts every cycle).
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/neuron_seq.sv
// Walks data/tap/bias memories for one layer and frames the neuron accumulation.
// Latency: reads start 1 cycle after start, results flagged PIPE_LAT after last; no backpressure.
module neuron_seq
    import neuron_seq_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int PIPE_LAT = 4
) (
    input  logic          clk,
    input  logic          reset,
    neuron_seq_if.slave   bus
);

    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [3:0]        DRAIN_END = 4'(PIPE_LAT - 1);

    seq_state_t state, next_state;

    logic [ADDR_W-1:0] taps_q, outs_q;
    logic [ADDR_W-1:0] tap_idx, out_idx, tap_cnt;
    logic [3:0]        drain_cnt;
    logic              done_q;
    logic              rd_en, start_ok, tap_end, out_end;

    assign rd_en    = (state == ST_RUN);
    // The idle cycle right after DONE still shows busy, so start is refused there too.
    assign start_ok = bus.start && (state == ST_IDLE) && !done_q;
    assign tap_end  = (tap_idx == taps_q - ONE);
    assign out_end  = (out_idx == outs_q - ONE);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_ok)
                    next_state = (bus.num_taps == '0 || bus.num_outs == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN:   if (tap_end && out_end) next_state = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == DRAIN_END) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Counters return to zero after the final read so idle addresses read as 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            taps_q    <= '0;
            outs_q    <= '0;
            tap_idx   <= '0;
            out_idx   <= '0;
            tap_cnt   <= '0;
            drain_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= (state == ST_DONE);
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 4'd1 : 4'd0;
            if (start_ok) begin
                taps_q  <= bus.num_taps;
                outs_q  <= bus.num_outs;
                tap_idx <= '0;
                out_idx <= '0;
                tap_cnt <= '0;
            end else if (rd_en) begin
                if (tap_end) begin
                    tap_idx <= '0;
                    out_idx <= out_end ? '0 : out_idx + ONE;
                end else begin
                    tap_idx <= tap_idx + ONE;
                end
                tap_cnt <= (tap_end && out_end) ? '0 : tap_cnt + ONE;
            end
        end
    end

    logic              f_valid, f_first, f_last;
    logic [ADDR_W-1:0] f_idx, last_idx_d;

    delay_line #(.WIDTH(3 + ADDR_W), .DEPTH(1)) u_frame (
        .clk   (clk),
        .reset (reset),
        .d     ({rd_en, rd_en && tap_idx == '0, rd_en && tap_end,
                 (rd_en && tap_end) ? out_idx : '0}),
        .q     ({f_valid, f_first, f_last, last_idx_d})
    );

    assign f_idx = last_idx_d;

    delay_line #(.WIDTH(1 + ADDR_W), .DEPTH(PIPE_LAT)) u_result (
        .clk   (clk),
        .reset (reset),
        .d     ({f_last, f_idx}),
        .q     ({bus.out_valid, bus.out_index})
    );

    assign bus.busy      = (state != ST_IDLE) || done_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en;
    assign bus.data_addr = tap_idx;
    assign bus.tap_addr  = tap_cnt;
    assign bus.bias_addr = out_idx;
    assign bus.in_valid  = f_valid;
    assign bus.first     = f_first;
    assign bus.last      = f_last;

endmodule

// File: tb/tb_neuron_seq.sv
// Cycle-by-cycle check of neuron_seq against a schedule computed from the layer shape.
module tb_neuron_seq;

    localparam int AW       = 10;
    localparam int PIPE_LAT = 4;
    localparam int MAXC     = 1600;

    typedef struct packed {
        logic          busy, done, rd_en;
        logic [AW-1:0] data_addr, tap_addr, bias_addr;
        logic          in_valid, first, last, out_valid;
        logic [AW-1:0] out_index;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    vec_t exp_q [MAXC];

    always #5 clk = ~clk;

    neuron_seq_if #(.ADDR_W(AW)) bus ();

    neuron_seq #(.ADDR_W(AW), .PIPE_LAT(PIPE_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t obs();
        return {bus.busy, bus.done, bus.rd_en, bus.data_addr, bus.tap_addr, bus.bias_addr,
                bus.in_valid, bus.first, bus.last, bus.out_valid, bus.out_index};
    endfunction

    // Expected waveform for a start accepted in cycle 0: reads k = 0..taps*outs-1 in cycle 1+k.
    task automatic build_exp(input int taps, input int outs, output int done_cyc);
        int n = taps * outs;
        for (int c = 0; c < MAXC; c++) exp_q[c] = '0;
        done_cyc = (n == 0) ? 2 : n + 2 + PIPE_LAT;
        for (int c = 1; c <= done_cyc; c++) exp_q[c].busy = 1'b1;
        exp_q[done_cyc].done = 1'b1;
        for (int k = 0; k < n; k++) begin
            exp_q[1+k].rd_en     = 1'b1;
            exp_q[1+k].data_addr = AW'(k % taps);
            exp_q[1+k].bias_addr = AW'(k / taps);
            exp_q[1+k].tap_addr  = AW'(k % 1024);
            exp_q[2+k].in_valid  = 1'b1;
            exp_q[2+k].first     = (k % taps == 0);
            exp_q[2+k].last      = (k % taps == taps - 1);
            if (k % taps == taps - 1) begin
                exp_q[2+k+PIPE_LAT].out_valid = 1'b1;
                exp_q[2+k+PIPE_LAT].out_index = AW'(k / taps);
            end
        end
    endtask

    task automatic test_reset();
        vec_t o;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.num_taps = '0;
        bus.num_outs = '0;
        repeat (3) @(negedge clk);
        o = obs();
        vectors++;
        if (o !== vec_t'(0)) begin
            miscompares++;
            $display("FAIL reset_held: got %h expected 0", o);
        end
        reset = 1'b0;
        @(negedge clk);
        o = obs();
        vectors++;
        if (o !== vec_t'(0)) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected 0", o);
        end
    endtask

    task automatic test_layer(input string name, input int taps, input int outs);
        int dc;
        vec_t o;
        build_exp(taps, outs, dc);
        for (int c = 0; c <= dc + 3; c++) begin
            o = obs();
            vectors++;
            if (o !== exp_q[c]) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, c, o, exp_q[c]);
            end
            bus.start    = (c == 0);
            bus.num_taps = AW'(taps);
            bus.num_outs = AW'(outs);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_restart_ignored();
        int dc;
        vec_t o;
        build_exp(3, 2, dc);
        for (int c = 0; c <= dc + 3; c++) begin
            o = obs();
            vectors++;
            if (o !== exp_q[c]) begin
                miscompares++;
                $display("FAIL restart_ignored cycle %0d: got %h expected %h", c, o, exp_q[c]);
            end
            bus.start    = (c == 0 || c == 3 || c == 7);
            bus.num_taps = (c == 0) ? AW'(3) : AW'(5);
            bus.num_outs = (c == 0) ? AW'(2) : AW'(7);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_abort();
        int dc;
        vec_t o;
        build_exp(3, 2, dc);
        for (int c = 5; c < MAXC; c++) exp_q[c] = '0;
        for (int c = 0; c <= dc + 3; c++) begin
            o = obs();
            vectors++;
            if (o !== exp_q[c]) begin
                miscompares++;
                $display("FAIL abort cycle %0d: got %h expected %h", c, o, exp_q[c]);
            end
            bus.start    = (c == 0);
            bus.num_taps = AW'(3);
            bus.num_outs = AW'(2);
            reset        = (c == 4);
            @(negedge clk);
        end
        bus.start = 1'b0;
        reset = 1'b0;
        test_layer("after_abort", 2, 3);
    endtask

    task automatic test_wrap();
        int dc, reads, results;
        vec_t o;
        reads = 0;
        results = 0;
        build_exp(512, 3, dc);
        for (int c = 0; c <= dc + 3; c++) begin
            o = obs();
            reads   += int'(o.rd_en);
            results += int'(o.out_valid);
            vectors++;
            if (o !== exp_q[c]) begin
                miscompares++;
                $display("FAIL wrap cycle %0d: got %h expected %h", c, o, exp_q[c]);
            end
            bus.start    = (c == 0);
            bus.num_taps = AW'(512);
            bus.num_outs = AW'(3);
            @(negedge clk);
        end
        bus.start = 1'b0;
        vectors++;
        if (reads !== 1536) begin
            miscompares++;
            $display("FAIL wrap_reads: got %0d expected 1536", reads);
        end
        vectors++;
        if (results !== 3) begin
            miscompares++;
            $display("FAIL wrap_results: got %0d expected 3", results);
        end
    endtask

    task automatic test_random();
        int dc, taps, outs;
        vec_t o;
        for (int it = 0; it < 12; it++) begin
            taps = $urandom_range(0, 7);
            outs = $urandom_range(0, 5);
            build_exp(taps, outs, dc);
            for (int c = 0; c <= dc + 3; c++) begin
                o = obs();
                vectors++;
                if (o !== exp_q[c]) begin
                    miscompares++;
                    $display("FAIL random it%0d (%0dx%0d) cycle %0d: got %h expected %h",
                             it, taps, outs, c, o, exp_q[c]);
                end
                bus.start    = (c == 0) || (c <= dc && $urandom_range(0, 3) == 0);
                bus.num_taps = (c == 0) ? AW'(taps) : AW'($urandom_range(0, 1023));
                bus.num_outs = (c == 0) ? AW'(outs) : AW'($urandom_range(0, 1023));
                @(negedge clk);
            end
            bus.start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_layer("basic_3x2", 3, 2);
        test_restart_ignored();
        test_layer("single_tap_1x4", 1, 4);
        test_layer("zero_outs", 3, 0);
        test_layer("zero_taps", 0, 4);
        test_abort();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
